mem_lane_unit: RTL and testbench
================================

# mem_lane_unit

Load/store lane unit between the datapath's memory stage and the word-organised synchronous data memory. It performs the narrowing and lane-placement direction for stores (sb/sh/sw byte enables and lane-replicated write data) and the extraction plus sign/zero extension for loads (lb/lbu/lh/lhu/lw). It uses a valid/ready request-response handshake and a small FSM to absorb the memory's one-cycle read latency. Misaligned or illegal accesses are flagged without touching memory.

## Interface
- No parameters; all addresses and data are 32 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; equals (state == IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_op` in 3: size/extension select.
  - 000: word.
  - 001: half signed.
  - 010: half unsigned.
  - 011: byte signed.
  - 100: byte unsigned.
  - 101–111: illegal.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `mem_en` out 1: memory access strobe, one cycle.
- `mem_we` out 4: byte write enables; bit i = byte lane i (bits 8i+7:8i).
- `mem_addr` out 32: word-aligned address, {req_addr[31:2], 2'b00}.
- `mem_wdata` out 32: lane-placed store data.
- `mem_rdata` in 32: read word, valid in the cycle after `mem_en`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 32: extended load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal request.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - A request is accepted on a rising edge with req_valid && req_ready.
  - On acceptance, op, we, addr and wdata are latched.
  - If the request is illegal, go to RESP with err = 1 and rdata = 0. No memory access is made.
  - Otherwise go to ISSUE.
- **Illegal conditions**
  - op in 101–111.
  - half access with addr[0] = 1.
  - word access with addr[1:0] != 0.
- **ISSUE**
  - mem_en = 1; mem_addr as defined above.
  - Loads: mem_we = 0000.
  - sw: mem_we = 1111; mem_wdata = wdata.
  - sh: mem_we = 0011 if addr[1] = 0, else 1100; mem_wdata = {2{wdata[15:0]}}.
  - sb (op 011 or 100): mem_we = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Next state: WAIT for a load; RESP for a store (err = 0, rdata = 0).
- **WAIT**
  - Select the lane of mem_rdata given by addr[1:0]:
    - byte: mem_rdata[8·addr[1:0] +: 8].
    - half: mem_rdata[16·addr[1] +: 16].
  - Extend it:
    - signed ops: replicate the MSB of the selected field.
    - unsigned ops: zero-fill.
    - word: pass mem_rdata through unchanged.
  - Register the result into rsp_rdata; go to RESP.
- **RESP**
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - Go to IDLE on an edge where rsp_ready = 1; otherwise stay.
- All memory-side and response outputs are registered.
- mem_en and mem_we are 1 only during ISSUE and 0 in every other state.

## Timing
- **Reset values** (while reset is low, and immediately after release):
  - state IDLE, so req_ready = 1.
  - mem_en = 0, mem_we = 0000, mem_addr = 0, mem_wdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- **Load latency.** Accept at edge E0. ISSUE occupies cycle E0–E1, WAIT occupies E1–E2, and rsp_valid rises after E2.
  - Minimum request-to-response is 3 cycles.
  - Throughput is at most one request every 4 cycles.
- **Store latency.** Accept at E0, ISSUE during E0–E1, rsp_valid after E1 (2 cycles).
- **Error latency.** rsp_valid rises after E0 (1 cycle).
- **Back-pressure.** The response is held indefinitely while rsp_ready = 0.
  - req_ready stays 0 throughout; the unit never queues a second request.
- **Response completion.** On the edge that completes the response (rsp_ready = 1 in RESP), req_ready becomes 1 the following cycle.
  - A request is never accepted in the same cycle as a response completes.
- **Input stability.** Inputs other than the req_* signals at the acceptance edge are ignored.
  - req_addr and req_wdata may change freely after acceptance.
- **Reset mid-operation.** Asserting reset in ISSUE, WAIT or RESP immediately returns the unit to IDLE and clears all outputs.
  - This includes forcing mem_we to 0 asynchronously, so no partial write occurs after the reset edge.
  - The aborted request produces no response.

## Test plan
- **sb.** Store, op 011, addr 0x0000_0013, wdata 0xFFFF_FFA5 → ISSUE:
  - mem_addr 0x0000_0010, mem_we 1000, mem_wdata 0xA5A5_A5A5.
  - rsp_valid 2 cycles after accept, rsp_err 0.
- **Byte loads.** With mem_rdata 0x80FF_7F01 in WAIT:
  - lb @0x…2 → rsp_rdata 0xFFFF_FFFF.
  - lbu @0x…2 → 0x0000_00FF.
  - lb @0x…1 → 0x0000_007F.
  - lb @0x…3 → 0xFFFF_FF80.
  - Each response arrives 3 cycles after accept.
- **Half loads and sh.**
  - lh @0x…2 with mem_rdata 0x8001_1234 → 0xFFFF_8001.
  - lhu @0x…2 on the same word → 0x0000_8001.
  - sh @0x…2, wdata 0x0000_BEEF → mem_we 1100, mem_wdata 0xBEEF_BEEF.
- **Errors.** lw @0x…6, sh @0x…1, and op 110 → each gives:
  - rsp_valid 1 cycle after accept, rsp_err 1, rsp_rdata 0.
  - mem_en never asserted.
- **Back-pressure.** Hold rsp_ready = 0 for 5 cycles after an lw response, with req_valid held at 1 throughout → rsp_rdata stable and req_ready 0. After rsp_ready pulses, the next request is accepted exactly one cycle later.
- **Reset during ISSUE of an sw.** Drive reset low → mem_en, mem_we, rsp_valid and rsp_rdata go to 0 immediately. After release, req_ready = 1 and no response appears for the aborted store.

Source files
------------

// File: rtl/mem_lane_unit.sv
// Load/store lane unit: places store bytes/halves onto word lanes and extracts+extends load lanes.
// Latency: load 3 cycles, store 2 cycles, error 1 cycle; responses held under rsp_ready back-pressure.
module mem_lane_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] OP_W   = 3'b000;
    localparam logic [2:0] OP_H   = 3'b001;
    localparam logic [2:0] OP_HU  = 3'b010;
    localparam logic [2:0] OP_B   = 3'b011;
    localparam logic [2:0] OP_BU  = 3'b100;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        we_q, we_d;
    logic [1:0]  lane_q, lane_d;
    logic        mem_en_q, mem_en_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        illegal;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;

    always_comb begin
        illegal = (req_op > OP_BU)
               || (((req_op == OP_H) || (req_op == OP_HU)) && req_addr[0])
               || ((req_op == OP_W) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        st_we    = 4'b0000;
        st_wdata = req_wdata;
        case (req_op)
            OP_W: begin
                st_we    = 4'b1111;
                st_wdata = req_wdata;
            end
            OP_H, OP_HU: begin
                st_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_we    = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
        endcase
    end

    // Lane extraction uses the address bits latched at acceptance, not the live request bus.
    always_comb begin
        rd_shift = mem_rdata >> {lane_q, 3'b000};
        byte_sel = rd_shift[7:0];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            OP_HU:   ld_data = {16'h0000, half_sel};
            OP_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            OP_BU:   ld_data = {24'h000000, byte_sel};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        we_d        = we_q;
        lane_d      = lane_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    we_d   = req_we;
                    lane_d = req_addr[1:0];
                    if (illegal) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we ? st_we : 4'b0000;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = st_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'h0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = ld_data;
            end
            default: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            we_q        <= 1'b0;
            lane_q      <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            we_q        <= we_d;
            lane_q      <= lane_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_lane_unit.sv
// Directed bench for mem_lane_unit with a one-cycle-latency word memory model.
module tb_mem_lane_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_word;
    int          n_chk;
    int          n_pass;

    mem_lane_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is only meaningful in the cycle after a strobe; otherwise poison it.
    always @(posedge clk) mem_rdata <= mem_en ? mem_word : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] word, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [3:0] exp_we,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata);
        int          lat;
        int          en_cnt;
        logic [3:0]  s_we;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        mem_word  = word;
        chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        lat     = 1;
        en_cnt  = 0;
        s_we    = 4'h0;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        while (!rsp_valid && lat < 10) begin
            if (mem_en) begin
                en_cnt++;
                s_we    = mem_we;
                s_addr  = mem_addr;
                s_wdata = mem_wdata;
            end
            step();
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".en_cnt"}, en_cnt, exp_err ? 0 : 1);
        if (!exp_err) begin
            chk({tag, ".mem_we"}, {28'd0, s_we}, {28'd0, exp_we});
            chk({tag, ".mem_addr"}, s_addr, exp_maddr);
            if (we) chk({tag, ".mem_wdata"}, s_wdata, exp_mwdata);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, ".done_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, ".done_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic        stable;
        int          lat;
        int          seen;
        n_chk     = 0;
        n_pass    = 0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        mem_word  = 32'h0;
        repeat (3) step();
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst.mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b1;
        step();
        chk("rel.req_ready", {31'd0, req_ready}, 32'd1);

        //      tag      we    op      addr          wdata         word          lat err rdata         we     maddr         mwdata
        do_req("sb",    1'b1, 3'b011, 32'h0000_0013, 32'hFFFF_FFA5, 32'h0,        2, 1'b0, 32'h0,        4'b1000, 32'h0000_0010, 32'hA5A5_A5A5);
        do_req("sw",    1'b1, 3'b000, 32'h0000_0040, 32'h1122_3344, 32'h0,        2, 1'b0, 32'h0,        4'b1111, 32'h0000_0040, 32'h1122_3344);
        do_req("sh2",   1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 32'h0,        2, 1'b0, 32'h0,        4'b1100, 32'h0000_0020, 32'hBEEF_BEEF);
        do_req("sh0",   1'b1, 3'b010, 32'h0000_0024, 32'h0000_1357, 32'h0,        2, 1'b0, 32'h0,        4'b0011, 32'h0000_0024, 32'h1357_1357);
        do_req("lb2",   1'b0, 3'b011, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0100, 32'h0);
        do_req("lbu2",  1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'h0000_00FF, 4'b0000, 32'h0000_0100, 32'h0);
        do_req("lb1",   1'b0, 3'b011, 32'h0000_0101, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'h0000_007F, 4'b0000, 32'h0000_0100, 32'h0);
        do_req("lb3",   1'b0, 3'b011, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0000_0100, 32'h0);
        do_req("lbu0",  1'b0, 3'b100, 32'h0000_0100, 32'h0,        32'h80FF_7F01, 3, 1'b0, 32'h0000_0001, 4'b0000, 32'h0000_0100, 32'h0);
        do_req("lh2",   1'b0, 3'b001, 32'h0000_0206, 32'h0,        32'h8001_1234, 3, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0000_0204, 32'h0);
        do_req("lhu2",  1'b0, 3'b010, 32'h0000_0206, 32'h0,        32'h8001_1234, 3, 1'b0, 32'h0000_8001, 4'b0000, 32'h0000_0204, 32'h0);
        do_req("lh0",   1'b0, 3'b001, 32'h0000_0204, 32'h0,        32'h8001_1234, 3, 1'b0, 32'h0000_1234, 4'b0000, 32'h0000_0204, 32'h0);
        do_req("lw",    1'b0, 3'b000, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 4'b0000, 32'h0000_0300, 32'h0);
        do_req("e_lw6", 1'b0, 3'b000, 32'h0000_0006, 32'h0,        32'h1111_1111, 1, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
        do_req("e_sh1", 1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1111_1111, 1, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
        do_req("e_op6", 1'b0, 3'b110, 32'h0000_0000, 32'h0,        32'h1111_1111, 1, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);

        // Back-pressure: lw response held while a new request waits on req_valid.
        mem_word  = 32'h1234_5678;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0000_0400;
        step();
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("bp.lat", lat, 3);
        chk("bp.rdata", rsp_rdata, 32'h1234_5678);
        held   = rsp_rdata;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_rdata !== held || req_ready !== 1'b0 || rsp_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp.stable", {31'd0, stable}, 32'd1);
        req_op    = 3'b100;
        req_addr  = 32'h0000_0403;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp.idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bp.no_same_cycle", {31'd0, mem_en}, 32'd0);
        step();
        req_valid = 1'b0;
        chk("bp.accept_ready", {31'd0, req_ready}, 32'd0);
        chk("bp.accept_en", {31'd0, mem_en}, 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("bp2.lat", lat, 3);
        chk("bp2.rdata", rsp_rdata, 32'h0000_0012);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset while a store is in ISSUE.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_op    = 3'b000;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'hCAFE_BABE;
        step();
        req_valid = 1'b0;
        chk("rmid.en_before", {31'd0, mem_en}, 32'd1);
        chk("rmid.we_before", {28'd0, mem_we}, 32'h0000_000F);
        #2 reset = 1'b0;
        #1;
        chk("rmid.en", {31'd0, mem_en}, 32'd0);
        chk("rmid.we", {28'd0, mem_we}, 32'd0);
        chk("rmid.valid", {31'd0, rsp_valid}, 32'd0);
        chk("rmid.rdata", rsp_rdata, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("rmid.ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || mem_en) seen++;
            step();
        end
        chk("rmid.no_rsp", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
